// File: rtl/tile_judge_pkg.sv
// Shared types and constants for the tile gameplay judge.
// Includes row codes, judge states and the streak bonus threshold.
package tile_pkg;
  localparam int COL_W        = 3;
  localparam int LIVES_W      = 3;
  localparam int STREAK_W     = 4;
  localparam int BONUS_STREAK = 10;
  localparam logic [COL_W-1:0] ROW_EMPTY = 3'b100;

  typedef enum logic [2:0] {
    EMPTY,
    LOAD,
    ARMED,
    TAPPED,
    OVER
  } judge_state_t;

  // Any code with the top bit set means the row carries no tile.
  function automatic logic row_is_empty(input logic [COL_W-1:0] code);
    return code[COL_W-1];
  endfunction
endpackage

// File: rtl/tile_judge_if.sv
// Key/row inputs and score/status outputs of the tile judge.
// STREAK_BONUS_EN adds the streak counter output.
interface tile_judge_if #(
  parameter int NUM_COLS = 4,
  parameter int SCORE_W  = 10
);
  import tile_pkg::*;

  logic [NUM_COLS-1:0] key_n;
  logic [COL_W-1:0]    line_bottom;
  logic                edge_go;
  logic                hit_pulse;
  logic                miss_pulse;
  logic [SCORE_W-1:0]  score;
  logic [LIVES_W-1:0]  lives;
  logic                game_over;
`ifdef STREAK_BONUS_EN
  logic [STREAK_W-1:0] streak;

  modport master (output key_n, line_bottom, edge_go,
                  input  hit_pulse, miss_pulse, score, lives, game_over, streak);
  modport slave  (input  key_n, line_bottom, edge_go,
                  output hit_pulse, miss_pulse, score, lives, game_over, streak);
`else
  modport master (output key_n, line_bottom, edge_go,
                  input  hit_pulse, miss_pulse, score, lives, game_over);
  modport slave  (input  key_n, line_bottom, edge_go,
                  output hit_pulse, miss_pulse, score, lives, game_over);
`endif
endinterface

// File: rtl/tile_judge_key_edge_sync.sv
// Two-flop synchroniser for one active-low push-button plus a falling-edge
// detector; a held key yields exactly one press pulse.
module key_edge_sync (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic press
);
  logic sync_p0, sync_p1, prev_p2;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  // Edge stage: released last cycle, pressed now.
  assign press = prev_p2 & ~sync_p1;
endmodule

// File: rtl/tile_judge.sv
// Gameplay judge: scores taps on the bottom row, tracks lives, raises game_over.
// STREAK_BONUS_EN enables the consecutive-hit bonus and the streak output.
module tile_judge
  import tile_pkg::*;
#(
  parameter int LIVES    = 3,
  parameter int SCORE_W  = 10,
  parameter int NUM_COLS = 4
) (
  input logic        clock,
  input logic        resetn,
  tile_judge_if.slave bus
);
  localparam int CIDX_W = COL_W - 1;

  logic [NUM_COLS-1:0] press;
  logic                press_any, hit, press_miss, scroll_miss, miss;
  logic [1:0]          inc;
  logic [CIDX_W-1:0]   col_q, eff_col;
  logic [NUM_COLS-1:0] col_onehot;
  judge_state_t        state, state_nxt, eff_state, tap_state;
  logic [SCORE_W-1:0]  score_q;
  logic [LIVES_W-1:0]  lives_q;
  logic                hit_q, miss_q, over_q;

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_key
    key_edge_sync u_sync (
      .clock  (clock),
      .resetn (resetn),
      .key_n  (bus.key_n[i]),
      .press  (press[i])
    );
  end

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + (SCORE_W+1)'(b);
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

`ifdef STREAK_BONUS_EN
  logic [STREAK_W-1:0] streak_q;
  logic                bonus;
  assign bonus = (streak_q == STREAK_W'(BONUS_STREAK - 1));
  assign inc   = bonus ? 2'd2 : 2'd1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   streak_q <= '0;
    else if (miss) streak_q <= '0;
    else if (hit)  streak_q <= bonus ? '0 : streak_q + 1'b1;
  end
  assign bus.streak = streak_q;
`else
  assign inc = 2'd1;
`endif

  assign press_any = |press;

  always_comb begin
    eff_state = state;
    eff_col   = col_q;
    // In LOAD the freshly shifted row is judged straight from the input.
    if (state == LOAD) begin
      eff_col   = bus.line_bottom[CIDX_W-1:0];
      eff_state = row_is_empty(bus.line_bottom) ? EMPTY : ARMED;
    end
    col_onehot  = NUM_COLS'(1) << eff_col;
    hit         = 1'b0;
    press_miss  = 1'b0;
    scroll_miss = 1'b0;
    if (state != OVER) begin
      hit        = press_any && (eff_state == ARMED) && (press == col_onehot);
      press_miss = press_any && !hit;
    end
    tap_state = hit ? TAPPED : eff_state;
    if (state != OVER) scroll_miss = bus.edge_go && (tap_state == ARMED);
    // A press miss and a scroll-off miss in one cycle cost a single life.
    miss      = press_miss | scroll_miss;
    state_nxt = tap_state;
    if (state == OVER)                           state_nxt = OVER;
    else if (miss && (lives_q == LIVES_W'(1)))   state_nxt = OVER;
    else if (bus.edge_go)                        state_nxt = LOAD;
  end

  always_ff @(posedge clock) begin
    col_q <= eff_col;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= EMPTY;
      score_q <= '0;
      lives_q <= LIVES_W'(LIVES);
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      hit_q  <= hit;
      miss_q <= miss;
      over_q <= (state_nxt == OVER);
      if (hit)  score_q <= sat_add(score_q, inc);
      if (miss) lives_q <= lives_q - LIVES_W'(1);
    end
  end

  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.game_over  = over_q;
endmodule

// File: doc/tile_judge.md
Name: tile_judge

Overview:
- Gameplay judge downstream of the row shifter; consumes the bottom visible row (line_6) and the four player keys.
- Decides hit or miss per row, keeps score and remaining lives, and raises game_over.
- Outputs feed the score display and the master control (game_over freezes play).

Parameters:
- LIVES, 3, misses allowed before game_over (1..7)
- SCORE_W, 10, score width; score saturates at 2^SCORE_W-1
- NUM_COLS, 4, tile columns = number of keys

Ports:
- clock  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset
- key_n  in  NUM_COLS  raw push-buttons, active-low, asynchronous
- line_bottom  in  3  bottom row code: 3'b000..3'b011 tile in column 0..3; 3'b1xx empty row
- edge_go  in  1  one-cycle pulse: rows shift this cycle; line_bottom holds the new row from the next cycle
- hit_pulse  out  1  one-cycle pulse on a correct tap
- miss_pulse  out  1  one-cycle pulse on each miss event
- score  out  SCORE_W  hits counted, saturating
- lives  out  3  remaining lives
- game_over  out  1  level, high in OVER state

Behaviour:
- Reset (async): score=0, lives=LIVES, hit_pulse=0, miss_pulse=0, game_over=0, state=EMPTY, synchronisers cleared to "released" (all 1).
- Key path: 2-flop synchroniser per key, then falling-edge detect -> press[i] one-cycle pulse. Press is judged 3 cycles after the pin falls (2 sync + edge). A held key produces a single press.
- States:
  - EMPTY: bottom row has no pending tile.
  - ARMED: bottom row holds an untapped tile.
  - TAPPED: tile already hit.
  - OVER.
- Press judging (any press[] nonzero, state != OVER):
  - ARMED, press == exactly one-hot of the tile column -> hit_pulse, score+1 (saturating), go TAPPED.
  - Anything else (wrong column, multiple keys, EMPTY, TAPPED) -> miss.
- Row change (edge_go, state != OVER):
  - If the state is still ARMED after press judging in the same cycle -> miss (tile scrolled off untapped).
  - Next state is taken from line_bottom sampled in the cycle after edge_go: tile -> ARMED, empty -> EMPTY.
  - A one-cycle LOAD substate holds that cycle; a press arriving during LOAD is judged against the new row.
- Simultaneous press and edge_go: the press is judged first against the current row; a correct tap avoids the scroll-off miss.
- Press miss plus scroll miss in the same cycle count as one miss only: one miss_pulse, lives-1.
- Miss: miss_pulse=1 for one cycle; lives decrements. If lives reaches 0 -> OVER, game_over=1.
- OVER: ignores keys and edge_go; score and lives frozen; exits only via resetn.
- All outputs registered; pulses are never asserted in OVER.

Optional Feature:
- Macro STREAK_BONUS_EN.
- Defined:
  - 4-bit streak counter of consecutive hits, cleared on any miss and on reset.
  - The 10th consecutive hit adds 2 to score instead of 1 (saturating) and resets the streak to 0.
  - Adds output port streak[3:0].
- Undefined: no streak logic or port; every hit adds 1.

Decomposition:
- Package tile_pkg:
  - ROW_EMPTY code (3'b100), column code width 3
  - judge state enum EMPTY/LOAD/ARMED/TAPPED/OVER
  - BONUS_STREAK constant 10
- Sub-module key_edge_sync (per-key 2-flop sync plus falling-edge pulse), instantiated NUM_COLS times.

Test Plan:
- Reset; line_bottom=2; pulse edge_go; press key_n[2] -> 3 cycles later hit_pulse=1, score=1, no miss.
- line_bottom=1 (ARMED); press key 3 -> miss_pulse=1, lives 3->2, score unchanged; second press on key 1 -> hit (still ARMED after wrong tap? no: wrong tap is a miss and stays ARMED) -> score=1.
- Tile row loaded; no press; edge_go -> miss_pulse=1, lives-1; third such row -> lives=0, game_over=1; further keys and edge_go leave score and lives frozen.
- Correct press edge and edge_go in the same cycle -> hit_pulse=1, no miss_pulse; next row (empty) -> state EMPTY.
- Keys 0 and 1 falling together with tile in column 0 -> one miss_pulse, lives-1, score unchanged; key held low 100 cycles -> only one press.
- Score preset near saturation (SCORE_W=4, 15 hits) -> 16th hit keeps score=15. With STREAK_BONUS_EN: 10 straight hits -> score=11, streak=0; a miss at hit 9 -> streak=0.
